// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for FFT64 output, using two ping-pong banks.
// Optional REORDER_SOF_EN adds a registered do_sof start-of-frame output aligned with do_en.
module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
`ifdef REORDER_SOF_EN
    ,
    output logic             do_sof
`endif
);

    localparam int unsigned LN = LOG_N;
    localparam int unsigned N  = 1 << LOG_N;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int unsigned i = 0; i < LN; i++) begin
            r[i] = a[LN-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [0:2*N-1];
    logic [2*WIDTH-1:0] rd_data_q;

    logic [LOG_N-1:0] wcnt_q, wcnt_d;
    logic [LOG_N-1:0] rcnt_q, rcnt_d;
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [0:0]       state_q, state_d;
    logic             rd_vld_q;
    logic             do_en_q;
    logic [WIDTH-1:0] do_re_q, do_im_q;
    logic             frame_done;
    logic             rd_en;

    assign frame_done = di_en && (wcnt_q == '1);
    assign rd_en      = (state_q == ST_READ);

    always_comb begin
        wcnt_d = wcnt_q;
        wsel_d = wsel_q;
        if (di_en) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        if (frame_done) begin
            wsel_d = ~wsel_q;
        end
    end

    // A frame finishing on the last read cycle chains straight into the next read.
    always_comb begin
        state_d = state_q;
        rsel_d  = rsel_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_done) begin
                    state_d = ST_READ;
                    rsel_d  = wsel_q;
                    rcnt_d  = '0;
                end
            end
            default: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == '1) begin
                    if (frame_done) begin
                        rsel_d = wsel_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (di_en) begin
            mem[{wsel_q, bitrev(wcnt_q)}] <= {di_re, di_im};
        end
        if (rd_en) begin
            rd_data_q <= mem[{rsel_q, rcnt_q}];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            state_q  <= ST_IDLE;
            rd_vld_q <= 1'b0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            do_en_q  <= rd_vld_q;
            if (rd_vld_q) begin
                do_re_q <= rd_data_q[2*WIDTH-1:WIDTH];
                do_im_q <= rd_data_q[WIDTH-1:0];
            end
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

`ifdef REORDER_SOF_EN
    logic rd_first_q;
    logic do_sof_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_first_q <= 1'b0;
            do_sof_q   <= 1'b0;
        end else begin
            rd_first_q <= rd_en && (rcnt_q == '0);
            do_sof_q   <= rd_vld_q && rd_first_q;
        end
    end

    assign do_sof = do_sof_q;
`endif

endmodule
